udp_tx_framer: RTL and testbench

- Sits directly upstream of the UDP complete stage on the transmit side.
- Takes a free-running 8-bit AXIS byte stream and cuts it into UDP datagrams.
- Frames on maximum size, input tlast, or idle timeout, buffering one datagram so the exact length is known before the header is issued.
- Drives the UDP header handshake (valid/ready) and the payload AXIS stream with a correct tlast and udp_length.

---
 rtl/udp_pkg.sv | 14 +
 rtl/udp_tx_framer_buf.sv | 28 ++
 rtl/udp_tx_framer.sv | 208 ++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: shared types and constants for the UDP transmit framer.
package udp_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HDR  = 2'd1,
      SEND = 2'd2
   } udp_tx_state_e;

   localparam int UDP_HDR_BYTES = 8;
   localparam int SEQ_BYTES     = 2;
   localparam int DEFAULT_TTL   = 64;

endpackage

// File: rtl/udp_tx_framer_buf.sv
// udp_tx_framer_buf: simple dual-port byte RAM holding one datagram payload.
// One write port and one read port with a registered output; the read
// register holds its value while rd_en is low, so it can drive a stalled stream.
module udp_tx_framer_buf #(
   parameter int ADDR_W = 10
) (
   input  logic              udp_sys_clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   // Write port
   always_ff @(posedge udp_sys_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port
   always_ff @(posedge udp_sys_clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: buffers an AXIS byte stream into one datagram at a time,
// then issues the UDP header followed by the payload stream.
// A datagram closes on PAYLOAD_MAX bytes, an input tlast, or an idle timeout.
// Build option UDP_TX_FRAMER_SEQ_EN: prefix every payload with a 16-bit
// big-endian sequence number (pkt_count at header issue).
module udp_tx_framer
   import udp_pkg::*;
#(
   parameter int PAYLOAD_MAX    = 64,
   parameter int BUF_ADDR_W     = 10,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TTL            = DEFAULT_TTL
) (
   input  logic        udp_sys_clk,
   input  logic        system_reset_n,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic [31:0] cfg_src_ip,
   input  logic [31:0] cfg_dst_ip,
   input  logic [15:0] cfg_src_port,
   input  logic [15:0] cfg_dst_port,
   output logic        udp_hdr_valid,
   input  logic        udp_hdr_ready,
   output logic [31:0] udp_ip_source_ip,
   output logic [31:0] udp_ip_dest_ip,
   output logic [15:0] udp_source_port,
   output logic [15:0] udp_dest_port,
   output logic [15:0] udp_length,
   output logic [15:0] udp_checksum,
   output logic [5:0]  udp_ip_dscp,
   output logic [1:0]  udp_ip_ecn,
   output logic [7:0]  udp_ip_ttl,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tkeep,
   output logic        m_tuser,
   output logic [15:0] pkt_count
);

`ifdef UDP_TX_FRAMER_SEQ_EN
   localparam int SEQ_LEN = SEQ_BYTES;
`else
   localparam int SEQ_LEN = 0;
`endif
   // count must hold PAYLOAD_MAX, which may equal the full buffer depth
   localparam int CW = BUF_ADDR_W + 1;

   udp_tx_state_e         state_q, state_n;
   logic [CW-1:0]         count_q, count_n;
   logic [CW-1:0]         idx_q, total;
   logic [31:0]           timer_q, timer_n;
   logic                  accept, enter_hdr, hdr_hs, last_hs, adv;
   logic                  m_tvalid_q, m_tlast_q;
   logic [15:0]           pkt_count_q;
   logic                  rd_en;
   logic [BUF_ADDR_W-1:0] rd_addr;
   logic [7:0]            rd_data, byte_out;

   assign s_tready  = (state_q == FILL);
   assign accept    = s_tvalid && s_tready;
   assign hdr_hs    = udp_hdr_valid && udp_hdr_ready;
   assign last_hs   = m_tvalid_q && m_tready && m_tlast_q;
   assign total     = count_q + CW'(SEQ_LEN);
   // load the output register whenever it is empty or draining and bytes remain
   assign adv       = (state_q == SEND) && (!m_tvalid_q || m_tready) && (idx_q != total);
   assign enter_hdr = (state_q == FILL) && (state_n == HDR);

   assign udp_checksum = 16'h0000;
   assign udp_ip_dscp  = 6'd0;
   assign udp_ip_ecn   = 2'd0;
   assign udp_ip_ttl   = 8'(TTL);
   assign m_tkeep      = 1'b1;
   assign m_tuser      = 1'b0;
   assign m_tvalid     = m_tvalid_q;
   assign m_tlast      = m_tlast_q;
   assign m_tdata      = m_tvalid_q ? byte_out : 8'h00;
   assign pkt_count    = pkt_count_q;

   udp_tx_framer_buf #(.ADDR_W(BUF_ADDR_W)) u_buf (
      .udp_sys_clk (udp_sys_clk),
      .wr_en       (accept),
      .wr_addr     (count_q[BUF_ADDR_W-1:0]),
      .wr_data     (s_tdata),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   // Next-state logic: fill/close decisions, idle timer, end of payload
   always_comb begin
      state_n = state_q;
      count_n = count_q;
      timer_n = timer_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               count_n = count_q + CW'(1);
               timer_n = '0;
               if (count_n == CW'(PAYLOAD_MAX) || s_tlast) state_n = HDR;
            end else if (count_q != '0 && TIMEOUT_CYCLES != 0) begin
               if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                  state_n = HDR;
                  timer_n = '0;
               end else begin
                  timer_n = timer_q + 32'd1;
               end
            end
         end
         HDR: begin
            if (hdr_hs) state_n = SEND;
         end
         SEND: begin
            if (last_hs) begin
               state_n = FILL;
               count_n = '0;
            end
         end
         default: state_n = FILL;
      endcase
   end

   // State, byte count and idle timer registers
   always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q <= FILL;
         count_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         timer_q <= timer_n;
      end
   end

   // Header capture on entry to HDR; fields hold until the handshake
   always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         udp_hdr_valid    <= 1'b0;
         udp_ip_source_ip <= '0;
         udp_ip_dest_ip   <= '0;
         udp_source_port  <= '0;
         udp_dest_port    <= '0;
         udp_length       <= '0;
      end else if (enter_hdr) begin
         udp_hdr_valid    <= 1'b1;
         udp_ip_source_ip <= cfg_src_ip;
         udp_ip_dest_ip   <= cfg_dst_ip;
         udp_source_port  <= cfg_src_port;
         udp_dest_port    <= cfg_dst_port;
         udp_length       <= 16'(count_n) + 16'(UDP_HDR_BYTES + SEQ_LEN);
      end else if (hdr_hs) begin
         udp_hdr_valid    <= 1'b0;
      end
   end

   // Payload output register (RAM read stage feeds data), send index, datagram count
   always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         idx_q       <= '0;
         pkt_count_q <= '0;
      end else begin
         if (adv) begin
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= (idx_q == total - CW'(1));
            idx_q      <= idx_q + CW'(1);
         end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
         end
         if (last_hs) begin
            idx_q       <= '0;
            pkt_count_q <= pkt_count_q + 16'd1;
         end
      end
   end

`ifdef UDP_TX_FRAMER_SEQ_EN
   logic [1:0]  sel_q;
   logic [15:0] seq_q;

   // Sequence number latched at header issue; sel_q marks which source owns the output byte
   always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         sel_q <= 2'd0;
         seq_q <= '0;
      end else begin
         if (enter_hdr) seq_q <= pkt_count_q;
         if (adv) sel_q <= (idx_q == '0) ? 2'd1 : (idx_q == CW'(1)) ? 2'd2 : 2'd0;
      end
   end

   assign rd_en    = adv && (idx_q >= CW'(SEQ_BYTES));
   assign rd_addr  = BUF_ADDR_W'(idx_q - CW'(SEQ_BYTES));
   assign byte_out = (sel_q == 2'd1) ? seq_q[15:8] :
                     (sel_q == 2'd2) ? seq_q[7:0]  : rd_data;
`else
   assign rd_en    = adv;
   assign rd_addr  = idx_q[BUF_ADDR_W-1:0];
   assign byte_out = rd_data;
`endif

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: directed bench for udp_tx_framer with a header/payload scoreboard.
// Follows the UDP_TX_FRAMER_SEQ_EN build option when it is defined.
module tb_udp_tx_framer;

   localparam int PMAX = 64;
   localparam int TOUT = 20;
   localparam int TTLV = 64;
`ifdef UDP_TX_FRAMER_SEQ_EN
   localparam int SEQ = 2;
`else
   localparam int SEQ = 0;
`endif

   logic        udp_sys_clk = 1'b0;
   logic        system_reset_n = 1'b1;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
   logic [31:0] cfg_src_ip = 32'h0A000001, cfg_dst_ip = 32'h0A000002;
   logic [15:0] cfg_src_port = 16'd1234, cfg_dst_port = 16'd5678;
   logic        udp_hdr_valid, udp_hdr_ready, m_tready;
   logic [31:0] udp_ip_source_ip, udp_ip_dest_ip;
   logic [15:0] udp_source_port, udp_dest_port, udp_length, udp_checksum, pkt_count;
   logic [5:0]  udp_ip_dscp;
   logic [1:0]  udp_ip_ecn;
   logic [7:0]  udp_ip_ttl, m_tdata;
   logic        m_tvalid, m_tlast, m_tkeep, m_tuser;

   udp_tx_framer #(.PAYLOAD_MAX(PMAX), .BUF_ADDR_W(10), .TIMEOUT_CYCLES(TOUT), .TTL(TTLV)) dut (
      .udp_sys_clk(udp_sys_clk), .system_reset_n(system_reset_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
      .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
      .udp_hdr_valid(udp_hdr_valid), .udp_hdr_ready(udp_hdr_ready),
      .udp_ip_source_ip(udp_ip_source_ip), .udp_ip_dest_ip(udp_ip_dest_ip),
      .udp_source_port(udp_source_port), .udp_dest_port(udp_dest_port),
      .udp_length(udp_length), .udp_checksum(udp_checksum),
      .udp_ip_dscp(udp_ip_dscp), .udp_ip_ecn(udp_ip_ecn), .udp_ip_ttl(udp_ip_ttl),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tkeep(m_tkeep), .m_tuser(m_tuser), .pkt_count(pkt_count)
   );

   always #5 udp_sys_clk = ~udp_sys_clk;

   typedef struct packed {
      logic [15:0] len;
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sp;
      logic [15:0] dp;
   } hdr_t;

   hdr_t        exp_hdr[$];
   logic [8:0]  exp_pay[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, last_acc = 0, pay_hs = 0;
   bit          bp_rand = 1'b0, chk_tout = 1'b0, last_done = 1'b0;
   logic [15:0] exp_pkts = '0;

   hdr_t        mon_h, mon_eh, prev_h;
   logic [8:0]  mon_p, mon_ep, prev_p;
   bit          hdr_wait = 1'b0, pay_wait = 1'b0, hv_prev = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge udp_sys_clk) cyc <= cyc + 1;

   // Ready generator: full throughput, or 50% random backpressure when bp_rand is set
   initial begin
      m_tready = 1'b1;
      udp_hdr_ready = 1'b1;
      forever begin
         @(posedge udp_sys_clk);
         #1;
         m_tready      = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         udp_hdr_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: handshakes seen at the negedge complete at the following posedge
   always @(negedge udp_sys_clk) begin
      mon_h = {udp_length, udp_ip_source_ip, udp_ip_dest_ip, udp_source_port, udp_dest_port};
      mon_p = {m_tlast, m_tdata};
      if (!system_reset_n) begin
         hdr_wait = 1'b0;
         pay_wait = 1'b0;
         hv_prev  = 1'b0;
      end else begin
         chk("hdr_pay_overlap", 128'(udp_hdr_valid && m_tvalid), 128'(0));
         if (hdr_wait) chk("hdr_stable", 128'({udp_hdr_valid, mon_h}), 128'({1'b1, prev_h}));
         if (pay_wait) chk("pay_stable", 128'({m_tvalid, mon_p}), 128'({1'b1, prev_p}));
         if (udp_hdr_valid && !hv_prev && chk_tout) begin
            chk("timeout_latency", 128'(cyc - last_acc), 128'(TOUT));
            chk_tout = 1'b0;
         end
         if (udp_hdr_valid && udp_hdr_ready) begin
            mon_eh = 'x;
            if (exp_hdr.size() > 0) mon_eh = exp_hdr.pop_front();
            chk("hdr_fields", 128'(mon_h), 128'(mon_eh));
            chk("hdr_const", 128'({udp_checksum, udp_ip_dscp, udp_ip_ecn, udp_ip_ttl, m_tkeep, m_tuser}),
                128'({16'h0, 6'h0, 2'h0, 8'(TTLV), 1'b1, 1'b0}));
         end
         if (m_tvalid && m_tready) begin
            mon_ep = 'x;
            if (exp_pay.size() > 0) mon_ep = exp_pay.pop_front();
            chk("payload", 128'(mon_p), 128'(mon_ep));
            pay_hs++;
            if (m_tlast) last_done = 1'b1;
         end
         hdr_wait = udp_hdr_valid && !udp_hdr_ready;
         pay_wait = m_tvalid && !m_tready;
         prev_h   = mon_h;
         prev_p   = mon_p;
         hv_prev  = udp_hdr_valid;
      end
   end

   task automatic tick();
      @(posedge udp_sys_clk);
      #1;
   endtask

   // Sequence prefix expected ahead of this datagram's data (none in the default build)
   task automatic begin_dgram();
      for (int i = 0; i < SEQ; i++)
         exp_pay.push_back({1'b0, (i == 0) ? exp_pkts[15:8] : exp_pkts[7:0]});
   endtask

   task automatic push_hdr(input int n);
      exp_hdr.push_back({16'(n + 8 + SEQ), cfg_src_ip, cfg_dst_ip, cfg_src_port, cfg_dst_port});
      exp_pkts++;
   endtask

   // Offer one byte until accepted; el is the expected m_tlast for that byte
   task automatic send_byte(input logic [7:0] d, input logic tl, input logic el);
      int  n;
      bit  acc;
      s_tdata  = d;
      s_tlast  = tl;
      s_tvalid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 2000) begin
         @(negedge udp_sys_clk);
         acc = s_tready;
         tick();
         n++;
      end
      chk("byte_accepted", 128'(acc), 128'(1));
      if (acc) exp_pay.push_back({el, d});
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      last_acc = cyc;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(exp_hdr.size() == 0 && exp_pay.size() == 0 && s_tready && !m_tvalid) && n < 3000) begin
         tick();
         n++;
      end
      chk(tag, 128'(n < 3000), 128'(1));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_s_tready"}, 128'(s_tready), 128'(1));
      chk({tag, "_hdr_valid"}, 128'(udp_hdr_valid), 128'(0));
      chk({tag, "_m_tvalid"}, 128'(m_tvalid), 128'(0));
      chk({tag, "_m_tlast"}, 128'(m_tlast), 128'(0));
      chk({tag, "_m_tdata"}, 128'(m_tdata), 128'(0));
      chk({tag, "_pkt_count"}, 128'(pkt_count), 128'(0));
      chk({tag, "_hdr_fields"}, 128'({udp_length, udp_ip_source_ip, udp_ip_dest_ip, udp_source_port, udp_dest_port}), 128'(0));
   endtask

   initial begin
      int n, len, base;
      #1 system_reset_n = 1'b0;
      tick();
      tick();
      check_reset("reset");
      system_reset_n = 1'b1;
      tick();

      // 64 continuous bytes close on PAYLOAD_MAX
      begin_dgram();
      for (int i = 0; i < PMAX; i++) send_byte(8'(i), 1'b0, i == PMAX - 1);
      push_hdr(PMAX);
      wait_done("max_drain");
      chk("pkt_count_1", 128'(pkt_count), 128'(exp_pkts));

      // 5 bytes then idle: header exactly TOUT cycles after the last accept
      begin_dgram();
      for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0, i == 4);
      chk_tout = 1'b1;
      push_hdr(5);
      wait_done("timeout_drain");
      chk("timeout_fired", 128'(chk_tout), 128'(0));
      chk("pkt_count_2", 128'(pkt_count), 128'(exp_pkts));

      // tlast on the 3rd byte: immediate flush, input stalled until tlast handshake
      last_done = 1'b0;
      begin_dgram();
      for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), i == 2, i == 2);
      push_hdr(3);
      n = 0;
      while (!last_done && n < 500) begin
         @(negedge udp_sys_clk);
         if (!last_done) chk("tready_low", 128'(s_tready), 128'(0));
         n++;
      end
      chk("tlast_seen", 128'(last_done), 128'(1));
      tick();
      chk("tready_back", 128'(s_tready), 128'(1));
      wait_done("tlast_drain");

      // 10 random datagrams under 50% backpressure, cfg changed while the previous header is pending
      bp_rand = 1'b1;
      for (int k = 0; k < 10; k++) begin
         len = $urandom_range(1, PMAX);
         begin_dgram();
         for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1, i == len - 1);
         push_hdr(len);
         cfg_src_ip   = $urandom;
         cfg_dst_ip   = $urandom;
         cfg_src_port = 16'($urandom);
         cfg_dst_port = 16'($urandom);
      end
      wait_done("rand_drain");
      bp_rand = 1'b0;
      tick();
      chk("pkt_count_rand", 128'(pkt_count), 128'(exp_pkts));

      // Reset in the middle of a 40-byte payload
      base = pay_hs;
      begin_dgram();
      for (int i = 0; i < 40; i++) send_byte(8'h40 + 8'(i), i == 39, i == 39);
      push_hdr(40);
      n = 0;
      while (pay_hs < base + 10 && n < 2000) begin
         @(negedge udp_sys_clk);
         n++;
      end
      chk("reached_mid_send", 128'(pay_hs >= base + 10), 128'(1));
      tick();
      system_reset_n = 1'b0;
      exp_hdr.delete();
      exp_pay.delete();
      exp_pkts = '0;
      #1;
      check_reset("mid_reset");
      tick();
      system_reset_n = 1'b1;
      tick();

      // Two fresh 4-byte datagrams after the abort (sequence 0 then 1 when prefixed)
      begin_dgram();
      for (int i = 0; i < 4; i++) send_byte(8'(i), i == 3, i == 3);
      push_hdr(4);
      wait_done("post_reset_1");
      chk("pkt_count_post1", 128'(pkt_count), 128'(1));
      begin_dgram();
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), i == 3, i == 3);
      push_hdr(4);
      wait_done("post_reset_2");
      chk("pkt_count_post2", 128'(pkt_count), 128'(2));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
